inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL be the number of entries (power of two, 2..16).
REQ-002 Parameter IW, default 32, SHALL be the width of the instruction word.
REQ-003 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 fetch_valid  input  1  SHALL indicate that fetch presents an instruction this cycle.
REQ-006 fetch_inst  input  IW  SHALL carry the fetched instruction word.
REQ-007 fetch_pc  input  32  SHALL carry the PC of fetch_inst.
REQ-008 fetch_ready  output  1  SHALL indicate that the queue accepts an entry this cycle.
REQ-009 flush  input  1  SHALL request that all held entries be discarded (mispredict/redirect).
REQ-010 dec_stall  input  1  SHALL indicate that decode/dispatch cannot consume this cycle.
REQ-011 dec_valid  output  1  SHALL indicate that the head entry is presented.
REQ-012 dec_inst  output  IW  SHALL carry the head instruction.
REQ-013 opcode  output  6  SHALL equal dec_inst[IW-1:IW-6] and feed the decoder opcode input.
REQ-014 dec_pc  output  32  SHALL carry the PC of the head instruction.
REQ-015 count  output  log2(DEPTH)+1  SHALL report the number of held entries.
REQ-016 halted  output  1  SHALL be high while the queue is in the HALTED state.

Function
REQ-017 Enqueue SHALL occur on a rising edge when fetch_valid && fetch_ready; {fetch_inst, fetch_pc} is written at the tail and the tail pointer advances.
REQ-018 Dequeue SHALL occur on a rising edge when dec_valid && !dec_stall; the head pointer advances.
REQ-019 fetch_ready SHALL be combinational: (count != DEPTH) && !halted && !flush.
REQ-020 A full queue SHALL NOT accept an entry, even when a dequeue occurs in the same cycle (no full-bypass).
REQ-021 A simultaneous enqueue and dequeue on a non-full, non-empty queue SHALL leave count unchanged.
REQ-022 dec_valid SHALL be (count != 0); an enqueue into an empty queue becomes visible on the next cycle (latency 1, no fall-through).
REQ-023 With count == 0, dec_inst and dec_pc SHALL be all zeros, so opcode reads as NOP (6'b000000).
REQ-024 Head and tail pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-025 The state machine SHALL have two states: RUN and HALTED.
REQ-026 RUN -> HALTED SHALL occur when the enqueued instruction has opcode 6'b110001 (HALT); the HALT entry itself is stored.
REQ-027 HALTED -> RUN SHALL occur only on flush or reset; entries already held continue to drain while HALTED.
REQ-028 On flush, the next edge SHALL set count = 0, head = tail = 0 and state = RUN; flush overrides any enqueue or dequeue in that cycle.
REQ-029 Storage contents SHALL NOT be cleared by flush; only the pointers and count are reset.
REQ-030 Outputs other than fetch_ready SHALL depend only on registered state; there is no combinational path from fetch_* to dec_*.

Reset
REQ-031 While rst is high: count = 0, head = tail = 0, state = RUN, dec_valid = 0, dec_inst = 0, dec_pc = 0, halted = 0, fetch_ready = 1 (when flush = 0).
REQ-032 Assertion of rst mid-operation SHALL discard all entries immediately, without waiting for an edge.
REQ-033 After rst deasserts, the first enqueue SHALL be accepted on the first rising edge.

Verification
REQ-034 Fill/drain: dec_stall = 1; enqueue 0x04000000, 0x0C000000, 0x24000000, 0x38000000 -> count = 4, fetch_ready = 0; release dec_stall -> opcodes 0x01, 0x03, 0x09, 0x0E in order over 4 cycles, then dec_valid = 0 and opcode = 0.
REQ-035 Wrap: perform 6 enqueues interleaved with 6 dequeues at DEPTH = 4 -> FIFO order is preserved across pointer wrap, and count never exceeds 4.
REQ-036 Full plus dequeue: count = 4, fetch_valid = 1, dec_stall = 0 -> one dequeue, no enqueue, count = 3 after the edge.
REQ-037 HALT: enqueue 0xC4000000 followed by fetch_valid held high -> halted = 1 and fetch_ready = 0; HALT drains to decode; flush -> halted = 0 and count = 0.
REQ-038 Flush race: count = 2, with flush = 1, fetch_valid = 1 and dec_stall = 0 in the same cycle -> after the edge count = 0, dec_valid = 0, and the new instruction is not stored.
REQ-039 Async reset: assert rst between edges with count = 3 -> count = 0 and dec_valid = 0 before the next rising edge.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a circular FIFO of {inst, pc}
// with a RUN/HALTED state machine that stops accepting after a HALT opcode.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int IW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_valid,
  input  logic [IW-1:0]            fetch_inst,
  input  logic [31:0]              fetch_pc,
  output logic                     fetch_ready,
  input  logic                     flush,
  input  logic                     dec_stall,
  output logic                     dec_valid,
  output logic [IW-1:0]            dec_inst,
  output logic [5:0]               opcode,
  output logic [31:0]              dec_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [5:0] HALT_OP = 6'b110001;

  typedef enum logic {RUN, HALTED} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [IW-1:0]   inst_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];

  logic enq;
  logic deq;

  assign halted      = (state_q == HALTED);
  assign fetch_ready = (count_q != CW'(DEPTH)) && !halted && !flush;
  assign dec_valid   = (count_q != '0);
  assign enq         = fetch_valid && fetch_ready;
  assign deq         = dec_valid && !dec_stall;

  // Empty queue presents zeros so the decoder sees a NOP opcode.
  assign dec_inst = dec_valid ? inst_mem[head_q] : '0;
  assign dec_pc   = dec_valid ? pc_mem[head_q]   : '0;
  assign opcode   = dec_inst[IW-1:IW-6];
  assign count    = count_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      state_d = RUN;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        tail_d = tail_q + PW'(1);
      end
      if (deq) begin
        head_d = head_q + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (enq && (fetch_inst[IW-1:IW-6] == HALT_OP)) begin
        state_d = HALTED;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset and flush; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[tail_q] <= fetch_inst;
      pc_mem[tail_q]   <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed, table-driven bench for inst_queue at DEPTH=4, IW=32.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        flush;
  logic        dec_stall;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [5:0]  opcode;
  logic [31:0] dec_pc;
  logic [2:0]  count;
  logic        halted;

  int nChecks = 0;
  int nFails  = 0;

  inst_queue #(.DEPTH(4), .IW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_inst  (fetch_inst),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .dec_stall   (dec_stall),
    .dec_valid   (dec_valid),
    .dec_inst    (dec_inst),
    .opcode      (opcode),
    .dec_pc      (dec_pc),
    .count       (count),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fl;
    logic        stall;
    logic [2:0]  expCount;
    logic        expValid;
    logic [31:0] expInst;
    logic [31:0] expPc;
    logic        expHalted;
    logic        expReady;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fv, input logic [31:0] inst, input logic [31:0] pc,
                              input logic fl, input logic stall, input logic [2:0] c,
                              input logic v, input logic [31:0] ei, input logic [31:0] ep,
                              input logic h, input logic r);
    vec_t t;
    t.fv = fv; t.inst = inst; t.pc = pc; t.fl = fl; t.stall = stall;
    t.expCount = c; t.expValid = v; t.expInst = ei; t.expPc = ep;
    t.expHalted = h; t.expReady = r;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic checkAll(input string tag, input vec_t t);
    logic [31:0] wantInst;
    wantInst = t.expInst;
    checkOutput({tag, " count"},       32'(count),       32'(t.expCount));
    checkOutput({tag, " dec_valid"},   32'(dec_valid),   32'(t.expValid));
    checkOutput({tag, " dec_inst"},    dec_inst,         wantInst);
    checkOutput({tag, " opcode"},      32'(opcode),      32'(wantInst[31:26]));
    checkOutput({tag, " dec_pc"},      dec_pc,           t.expPc);
    checkOutput({tag, " halted"},      32'(halted),      32'(t.expHalted));
    checkOutput({tag, " fetch_ready"}, 32'(fetch_ready), 32'(t.expReady));
  endtask

  task automatic applyStimulus(input vec_t t);
    @(negedge clk);
    fetch_valid = t.fv;
    fetch_inst  = t.inst;
    fetch_pc    = t.pc;
    flush       = t.fl;
    dec_stall   = t.stall;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t rv;
    rst = 1'b1; fetch_valid = 1'b0; fetch_inst = '0; fetch_pc = '0;
    flush = 1'b0; dec_stall = 1'b0;

    // Fill with decode stalled, then drain; the 0x14 fetch while full must be refused.
    vecs.push_back(mk(1, 32'h0400_0000, 32'h100, 0, 1, 1, 1, 32'h0400_0000, 32'h100, 0, 1));
    vecs.push_back(mk(1, 32'h0C00_0000, 32'h104, 0, 1, 2, 1, 32'h0400_0000, 32'h100, 0, 1));
    vecs.push_back(mk(1, 32'h2400_0000, 32'h108, 0, 1, 3, 1, 32'h0400_0000, 32'h100, 0, 1));
    vecs.push_back(mk(1, 32'h3800_0000, 32'h10C, 0, 1, 4, 1, 32'h0400_0000, 32'h100, 0, 0));
    vecs.push_back(mk(1, 32'h1400_0000, 32'h110, 0, 0, 3, 1, 32'h0C00_0000, 32'h104, 0, 1));
    vecs.push_back(mk(0, 32'h0,         32'h0,   0, 0, 2, 1, 32'h2400_0000, 32'h108, 0, 1));
    vecs.push_back(mk(0, 32'h0,         32'h0,   0, 0, 1, 1, 32'h3800_0000, 32'h10C, 0, 1));
    vecs.push_back(mk(0, 32'h0,         32'h0,   0, 0, 0, 0, 32'h0,         32'h0,   0, 1));
    // Interleaved enqueue/dequeue across pointer wrap.
    vecs.push_back(mk(1, 32'h0800_0000, 32'h200, 0, 0, 1, 1, 32'h0800_0000, 32'h200, 0, 1));
    vecs.push_back(mk(1, 32'h1000_0000, 32'h204, 0, 0, 1, 1, 32'h1000_0000, 32'h204, 0, 1));
    vecs.push_back(mk(1, 32'h1800_0000, 32'h208, 0, 0, 1, 1, 32'h1800_0000, 32'h208, 0, 1));
    vecs.push_back(mk(1, 32'h2000_0000, 32'h20C, 0, 0, 1, 1, 32'h2000_0000, 32'h20C, 0, 1));
    vecs.push_back(mk(1, 32'h2800_0000, 32'h210, 0, 0, 1, 1, 32'h2800_0000, 32'h210, 0, 1));
    vecs.push_back(mk(1, 32'h3000_0000, 32'h214, 0, 0, 1, 1, 32'h3000_0000, 32'h214, 0, 1));
    vecs.push_back(mk(0, 32'h0,         32'h0,   0, 0, 0, 0, 32'h0,         32'h0,   0, 1));
    // HALT stops intake, drains, and flush returns to RUN.
    vecs.push_back(mk(1, 32'h0C00_0000, 32'h300, 0, 1, 1, 1, 32'h0C00_0000, 32'h300, 0, 1));
    vecs.push_back(mk(1, 32'hC400_0000, 32'h304, 0, 1, 2, 1, 32'h0C00_0000, 32'h300, 1, 0));
    vecs.push_back(mk(1, 32'h0400_0000, 32'h308, 0, 0, 1, 1, 32'hC400_0000, 32'h304, 1, 0));
    vecs.push_back(mk(1, 32'h0400_0000, 32'h308, 0, 0, 0, 0, 32'h0,         32'h0,   1, 0));
    vecs.push_back(mk(1, 32'h0400_0000, 32'h308, 1, 0, 0, 0, 32'h0,         32'h0,   0, 0));
    vecs.push_back(mk(1, 32'h0400_0000, 32'h400, 0, 1, 1, 1, 32'h0400_0000, 32'h400, 0, 1));
    // Flush racing an enqueue and a dequeue.
    vecs.push_back(mk(1, 32'h0C00_0000, 32'h404, 0, 1, 2, 1, 32'h0400_0000, 32'h400, 0, 1));
    vecs.push_back(mk(1, 32'h2400_0000, 32'h408, 1, 0, 0, 0, 32'h0,         32'h0,   0, 0));
    vecs.push_back(mk(0, 32'h0,         32'h0,   0, 1, 0, 0, 32'h0,         32'h0,   0, 1));

    repeat (2) @(posedge clk);
    #1;
    rv = mk(0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1);
    checkAll("reset", rv);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("vec%0d", i), vecs[i]);
    end

    // Async reset between edges with three entries held.
    @(negedge clk);
    fetch_valid = 1'b1; dec_stall = 1'b1; fetch_inst = 32'h0400_0000; fetch_pc = 32'h500;
    @(negedge clk);
    fetch_inst = 32'h0C00_0000; fetch_pc = 32'h504;
    @(negedge clk);
    fetch_inst = 32'h2400_0000; fetch_pc = 32'h508;
    @(posedge clk);
    #1;
    checkOutput("pre-reset count", 32'(count), 32'd3);
    @(negedge clk);
    fetch_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async count",     32'(count),       32'd0);
    checkOutput("async dec_valid", 32'(dec_valid),   32'd0);
    checkOutput("async dec_inst",  dec_inst,         32'h0);
    checkOutput("async dec_pc",    dec_pc,           32'h0);
    checkOutput("async ready",     32'(fetch_ready), 32'd1);

    // First enqueue after reset release lands on the first edge, no fall-through.
    @(negedge clk);
    rst = 1'b0;
    fetch_valid = 1'b1; fetch_inst = 32'h3800_0000; fetch_pc = 32'h600;
    #1;
    checkOutput("nofall dec_valid", 32'(dec_valid),   32'd0);
    checkOutput("nofall opcode",    32'(opcode),      32'd0);
    checkOutput("nofall ready",     32'(fetch_ready), 32'd1);
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
    checkOutput("post-rst count",    32'(count),  32'd1);
    checkOutput("post-rst dec_inst", dec_inst,    32'h3800_0000);
    checkOutput("post-rst opcode",   32'(opcode), 32'h0E);
    checkOutput("post-rst dec_pc",   dec_pc,      32'h600);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
